// File: rtl/stream_mux_rr_pkg.sv
// ----------------------------------------------------------------------------
// stream_mux_rr_pkg
// Shared helper functions for the registered round-robin stream mux.
//   clog2     : ceiling log2 of a positive integer (clog2(1) = 0)
//   sel_width : width of a stream index; never narrower than one bit
// ----------------------------------------------------------------------------
package stream_mux_rr_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // A single-input mux still needs a 1-bit index port.
    function automatic int sel_width(input int num_input);
        return (num_input <= 1) ? 1 : clog2(num_input);
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a rotating priority pointer.
//   clk, rst    : clock, asynchronous active-high reset (clears ptr)
//   req         : per-stream request vector
//   enable      : when low, no grant is produced
//   advance     : the current grant was consumed; move ptr past it
//   grant       : one-hot grant
//   grant_idx   : encoded index of the granted stream
//   grant_valid : some stream is granted
// Priority starts at ptr and wraps modulo NUM_INPUT, which need not be a
// power of two.
// ----------------------------------------------------------------------------
module rr_arbiter
    import stream_mux_rr_pkg::*;
#(
    parameter  int NUM_INPUT = 4,
    localparam int SEL_W     = sel_width(NUM_INPUT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_INPUT-1:0] req,
    input  logic                 enable,
    input  logic                 advance,
    output logic [NUM_INPUT-1:0] grant,
    output logic [SEL_W-1:0]     grant_idx,
    output logic                 grant_valid
);

    logic [SEL_W-1:0] ptr;

    // Scan from the furthest offset down to offset 0 so the candidate
    // closest to ptr is the one left standing.
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] cand;
        // NOTE: every variable written here gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        idx         = 0;
        cand        = '0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        if (enable) begin
            for (int off = NUM_INPUT - 1; off >= 0; off--) begin
                idx = int'(ptr) + off;
                if (idx >= NUM_INPUT) begin
                    idx = idx - NUM_INPUT;
                end
                cand = SEL_W'(idx);
                if (req[cand]) begin
                    grant       = '0;
                    grant[cand] = 1'b1;
                    grant_idx   = cand;
                    grant_valid = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is updated with non-blocking assignments
        // only, so every flop samples pre-edge values.
        if (rst) begin
            ptr <= '0;
        end else if (advance && grant_valid) begin
            ptr <= (grant_idx == SEL_W'(NUM_INPUT - 1)) ? '0 : grant_idx + SEL_W'(1);
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// ----------------------------------------------------------------------------
// stream_mux_rr
// Registered, handshaked NUM_INPUT-to-1 stream multiplexer. One input stream
// is chosen by an external select (mode=0) or round-robin (mode=1) and its
// word is forwarded through a one-entry output register.
//   clk, rst   : clock, asynchronous active-high reset
//   in_data    : flattened inputs, stream i at [i*BIT_WIDTH +: BIT_WIDTH]
//   in_valid   : per-stream valid
//   in_ready   : per-stream ready, at most one bit high
//   mode       : 0 = fixed select, 1 = round-robin
//   select     : source index used in fixed mode (>= NUM_INPUT grants none)
//   out_data   : registered output word
//   out_valid  : output register holds a word
//   out_ready  : consumer accepts the word
//   out_src    : index of the stream that produced out_data
// Outputs are purely registered; in_ready is combinational from
// out_ready, in_valid, mode and select, never from in_data.
// ----------------------------------------------------------------------------
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter  int NUM_INPUT = 4,
    parameter  int BIT_WIDTH = 8,
    localparam int SEL_W     = sel_width(NUM_INPUT)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_INPUT*BIT_WIDTH-1:0] in_data,
    input  logic [NUM_INPUT-1:0]           in_valid,
    output logic [NUM_INPUT-1:0]           in_ready,
    input  logic                           mode,
    input  logic [SEL_W-1:0]               select,
    output logic [BIT_WIDTH-1:0]           out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SEL_W-1:0]               out_src
);

    logic                 load_en;
    logic [NUM_INPUT-1:0] fixed_grant;
    logic                 fixed_valid;
    logic [NUM_INPUT-1:0] rr_grant;
    logic [SEL_W-1:0]     rr_idx;
    logic                 rr_valid;
    logic [NUM_INPUT-1:0] grant_vec;
    logic [SEL_W-1:0]     grant_idx;
    logic                 grant_any;
    logic [BIT_WIDTH-1:0] grant_word;

    // The register can take a new word when empty or when its word leaves
    // in this same cycle.
    assign load_en = !out_valid || out_ready;

    // Fixed path: an out-of-range select simply matches no stream.
    always_comb begin
        fixed_grant = '0;
        fixed_valid = 1'b0;
        for (int i = 0; i < NUM_INPUT; i++) begin
            if (select == SEL_W'(i) && in_valid[i]) begin
                fixed_grant[i] = 1'b1;
                fixed_valid    = 1'b1;
            end
        end
    end

    // ptr only moves on an actual round-robin transfer.
    rr_arbiter #(
        .NUM_INPUT (NUM_INPUT)
    ) u_arbiter (
        .clk         (clk),
        .rst         (rst),
        .req         (in_valid),
        .enable      (mode),
        .advance     (mode && load_en),
        .grant       (rr_grant),
        .grant_idx   (rr_idx),
        .grant_valid (rr_valid)
    );

    assign grant_vec = mode ? rr_grant : fixed_grant;
    assign grant_idx = mode ? rr_idx   : select;
    assign grant_any = mode ? rr_valid : fixed_valid;

    // No ready is offered while reset is held.
    assign in_ready = (load_en && !rst) ? grant_vec : '0;

    // One-hot select of the granted word; all zeros when nothing is granted.
    always_comb begin
        grant_word = '0;
        for (int i = 0; i < NUM_INPUT; i++) begin
            if (grant_vec[i]) begin
                grant_word = in_data[i*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (load_en) begin
            if (grant_any) begin
                out_valid <= 1'b1;
                out_data  <= grant_word;
                out_src   <= grant_idx;
            end else begin
                // Either already empty or the held word just drained.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// ----------------------------------------------------------------------------
// tb_stream_mux_rr
// Directed bench for stream_mux_rr. The main instance (4 streams, 8 bits)
// is checked through a scoreboard: each expected grant pushes the expected
// {src, data} when the stimulus is issued, and a negedge monitor pops and
// compares on every output transfer. A 5-stream/16-bit and a 1-stream/1-bit
// instance cover out-of-range select, non-power-of-two wrap and SEL_W=1.
// ----------------------------------------------------------------------------
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Main instance: NUM_INPUT=4, BIT_WIDTH=8
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  select;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_src;

    stream_mux_rr #(.NUM_INPUT(4), .BIT_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .select(select),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_src(out_src)
    );

    // Second instance: NUM_INPUT=5, BIT_WIDTH=16
    logic [79:0] in_data5;
    logic [4:0]  in_valid5;
    logic [4:0]  in_ready5;
    logic        mode5;
    logic [2:0]  select5;
    logic [15:0] out_data5;
    logic        out_valid5;
    logic        out_ready5;
    logic [2:0]  out_src5;

    stream_mux_rr #(.NUM_INPUT(5), .BIT_WIDTH(16)) u_dut5 (
        .clk(clk), .rst(rst), .in_data(in_data5), .in_valid(in_valid5),
        .in_ready(in_ready5), .mode(mode5), .select(select5),
        .out_data(out_data5), .out_valid(out_valid5), .out_ready(out_ready5),
        .out_src(out_src5)
    );

    // Third instance: NUM_INPUT=1, BIT_WIDTH=1
    logic [0:0] in_data1;
    logic [0:0] in_valid1;
    logic [0:0] in_ready1;
    logic       mode1;
    logic [0:0] select1;
    logic [0:0] out_data1;
    logic       out_valid1;
    logic       out_ready1;
    logic [0:0] out_src1;

    stream_mux_rr #(.NUM_INPUT(1), .BIT_WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .mode(mode1), .select(select1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_src(out_src1)
    );

    typedef struct {
        logic [1:0] src;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   xfers = 0;
    int   seq   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Word carried by stream g during stimulus step s.
    function automatic logic [7:0] word(input int s, input int g);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(s);
        lo = 4'(g);
        return {hi, lo};
    endfunction

    task automatic drive(input logic [3:0] v);
        in_valid = v;
        for (int i = 0; i < 4; i++) begin
            in_data[i*8 +: 8] = word(seq, i);
        end
    endtask

    // Apply one cycle of stimulus, check the expected in_ready and, when a
    // grant is expected, push the word that must later appear at the output.
    task automatic step(input string name, input logic m, input logic [1:0] sel,
                        input logic [3:0] v, input logic [3:0] exp_rdy);
        mode   = m;
        select = sel;
        drive(v);
        #1;
        check(name, in_ready, exp_rdy);
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) begin
                sb.push_back('{src: 2'(i), data: word(seq, i)});
            end
        end
        cycle();
        seq++;
    endtask

    // Monitor: a transfer happens at the next rising edge whenever
    // out_valid && out_ready is seen here.
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready_onehot", 32'($countones(in_ready) <= 1), 1);
            check("in_ready5_onehot", 32'($countones(in_ready5) <= 1), 1);
            if (out_valid && out_ready) begin
                xfers++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: got src=%0d data=%0h, expected no transfer", out_src, out_data);
                end else begin
                    mon_e = sb.pop_front();
                    check("sb_data", out_data, mon_e.data);
                    check("sb_src", out_src, mon_e.src);
                end
            end
        end
    end

    initial begin
        int base;
        int hold_seq;

        in_valid   = '0; in_data  = '0; mode  = 1'b1; select  = '0; out_ready  = 1'b1;
        in_valid5  = '0; in_data5 = '0; mode5 = 1'b0; select5 = '0; out_ready5 = 1'b1;
        in_valid1  = '0; in_data1 = '0; mode1 = 1'b1; select1 = '0; out_ready1 = 1'b1;

        // Reset state, with all streams requesting
        #1 rst = 1'b1;
        #1 in_valid = 4'hF;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_src", out_src, 0);
        cycle();
        rst = 1'b0;
        in_valid = '0;

        // Round-robin fairness: 0,1,2,3,0,1,2,3 at one word per cycle
        base = xfers;
        for (int k = 0; k < 8; k++) begin
            step("rr_fair", 1'b1, 2'd0, 4'hF, 4'b0001 << (k % 4));
        end
        step("rr_fair_drain", 1'b1, 2'd0, 4'h0, 4'h0);
        check("rr_throughput", 32'(xfers - base), 8);
        check("rr_sb_empty", 32'(sb.size()), 0);

        // Skip and wrap: ptr=1 with streams 0 and 3 requesting -> 3,0,3
        step("rr_set_ptr", 1'b1, 2'd0, 4'b0001, 4'b0001);
        step("rr_skip", 1'b1, 2'd0, 4'b1001, 4'b1000);
        step("rr_wrap", 1'b1, 2'd0, 4'b1001, 4'b0001);
        step("rr_skip2", 1'b1, 2'd0, 4'b1001, 4'b1000);

        // Fixed select leaves ptr alone; ptr=2 is still in force afterwards
        step("rr_ptr_to_2", 1'b1, 2'd0, 4'b0010, 4'b0010);
        for (int k = 0; k < 3; k++) begin
            step("fixed_sel2", 1'b0, 2'd2, 4'hF, 4'b0100);
        end
        step("fixed_sel2_novalid", 1'b0, 2'd2, 4'b1011, 4'b0000);
        step("mode_back_rr", 1'b1, 2'd2, 4'hF, 4'b0100);
        step("fixed_drain", 1'b1, 2'd0, 4'h0, 4'h0);
        check("fixed_sb_empty", 32'(sb.size()), 0);

        // Backpressure: ptr=3, word from stream 3 held for three cycles
        out_ready = 1'b0;
        hold_seq  = seq;
        step("bp_load", 1'b1, 2'd0, 4'hF, 4'b1000);
        for (int k = 0; k < 3; k++) begin
            mode = 1'b1;
            drive(4'hF);
            #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, word(hold_seq, 3));
            check("bp_out_src", out_src, 3);
            cycle();
            seq++;
        end
        out_ready = 1'b1;
        step("bp_release", 1'b1, 2'd0, 4'hF, 4'b0001);
        step("bp_drain", 1'b1, 2'd0, 4'h0, 4'h0);
        check("bp_sb_empty", 32'(sb.size()), 0);

        // Reset mid-stream: held word from stream 1 (ptr then 2) is discarded
        out_ready = 1'b0;
        mode = 1'b1;
        drive(4'hF);
        #1;
        check("pre_rst_in_ready", in_ready, 4'b0010);
        cycle();
        seq++;
        check("pre_rst_out_valid", out_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_data", out_data, 0);
        check("async_rst_out_src", out_src, 0);
        check("async_rst_in_ready", in_ready, 0);
        cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        step("post_rst_rr", 1'b1, 2'd0, 4'hF, 4'b0001);
        step("post_rst_drain", 1'b1, 2'd0, 4'h0, 4'h0);
        check("post_rst_sb_empty", 32'(sb.size()), 0);

        // Five streams: out-of-range select never grants
        for (int i = 0; i < 5; i++) begin
            in_data5[i*16 +: 16] = 16'hA000 + 16'(i);
        end
        in_valid5 = 5'h1F;
        mode5 = 1'b0;
        for (int s = 5; s < 8; s++) begin
            select5 = 3'(s);
            #1;
            check("fix5_no_grant", in_ready5, 0);
            cycle();
            check("fix5_no_valid", out_valid5, 0);
        end
        select5 = 3'd4;
        #1;
        check("fix5_sel4_ready", in_ready5, 5'b10000);
        cycle();
        check("fix5_sel4_valid", out_valid5, 1);
        check("fix5_sel4_src", out_src5, 4);
        check("fix5_sel4_data", out_data5, 16'hA004);

        // Five streams round-robin: 0,1,2,3,4,0
        mode5 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr5_grant", in_ready5, 32'(5'b00001 << (k % 5)));
            cycle();
            check("rr5_src", out_src5, 32'(k % 5));
            check("rr5_data", out_data5, 32'(16'hA000 + 16'(k % 5)));
        end
        in_valid5 = '0;
        cycle();

        // Single stream, 1-bit data
        in_valid1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data1 = 1'(k & 1);
            #1;
            check("one_ready", in_ready1, 1);
            cycle();
            check("one_valid", out_valid1, 1);
            check("one_data", out_data1, 32'(k & 1));
            check("one_src", out_src1, 0);
        end
        in_valid1 = '0;
        cycle();

        check("final_sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
